vl_strip_sequencer: RTL
=======================

# vl_strip_sequencer

Strip-mining controller for the vector unit. It accepts one vector operation configuration: SEW encoding, LMUL encoding and application vector length (AVL). It computes VLMAX = (VLEN/SEW)·LMUL, then issues a sequence of per-strip vector lengths to the vector datapath over a valid/ready handshake until the AVL is exhausted. It sits between instruction decode (configuration side) and the vector lane datapath (strip side), and replaces per-instruction combinational vl computation with a sequenced, back-pressurable stream.

## Interface
Parameters:
- VLEN, 128: vector register length in bits; power of two, 128..1024.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  sequencer idle and able to accept a configuration
- sew_enc  in  3  000=8, 001=16, 010=32, 011=64, 100=128; 101..111 illegal
- lmul_enc  in  3  000=1, 001=2, 010=4, 011=8, 100=16; 101..111 illegal
- avl  in  9  requested element count, 0..256
- abort  in  1  kill the current operation (trap/flush)
- strip_valid  out  1  strip descriptor valid
- strip_ready  in  1  datapath accepts strip
- strip_vl  out  9  element count of this strip, 1..256
- strip_idx  out  8  strip number within the operation, starting at 0
- strip_last  out  1  this strip is the final one
- busy  out  1  operation in progress (state ≠ IDLE)
- done  out  1  one-cycle pulse: operation complete
- err  out  1  one-cycle pulse: illegal encoding rejected

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: cfg_ready=1. On cfg_valid&cfg_ready:
  - sew_enc>4 or lmul_enc>4: err=1 next cycle, remain IDLE, no strips.
  - Otherwise, avl=0: done=1 next cycle, remain IDLE, no strips.
  - Otherwise: latch vlmax = (VLEN >> (3+sew_enc)) << lmul_enc, set rem=avl, idx=0, go to ISSUE.
- vlmax is held in a 9-bit register. For VLEN=128 its range is 1..256. For larger VLEN, saturate vlmax at 256.
- ISSUE: strip_valid=1, strip_vl=min(rem, vlmax), strip_last=(rem≤vlmax), strip_idx=idx.
  - On strip_valid&strip_ready: rem←rem−strip_vl and idx←idx+1.
  - If strip_last, go to DONE; otherwise stay in ISSUE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Strip count equals ceil(avl/vlmax). The sum of strip_vl over all strips equals avl exactly.
- abort has priority over the handshake.
  - In ISSUE or DONE: next state IDLE, strip_valid deasserts next cycle, no done pulse.
  - A strip handshaking in the same cycle as abort counts as consumed by the datapath.
  - abort in IDLE has no effect.
- cfg_valid is ignored outside IDLE. Configuration inputs are sampled only at acceptance.

## Timing
- Reset values: state=IDLE; strip_valid, strip_vl, strip_idx, strip_last, busy, done, err = 0; rem and vlmax = 0; cfg_ready=1 from the first cycle after rst deasserts. Inputs are ignored while rst=1.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values, and no done pulse.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- Acceptance at edge N puts the first strip valid in cycle N+1.
- With strip_ready held high, strips are issued one per cycle, back-to-back.
- done is high in the cycle after the last strip handshake. cfg_ready returns high the cycle after that.
- Minimum turnaround for a 1-strip operation is 3 cycles from acceptance to next acceptance.
- Backpressure: while strip_valid&!strip_ready, strip_vl, strip_idx and strip_last hold stable. strip_valid never drops without a handshake, except on abort or rst.
- err and done are single-cycle pulses and never coincide.

## Test plan
- sew=000, lmul=000, avl=40, ready=1: strips vl=16,16,8 with idx 0,1,2; last only on idx 2; done one cycle after the third handshake; cfg_ready back one cycle after done.
- sew=100, lmul=000, avl=256: 256 strips of vl=1, idx 0..255, last at idx 255. sew=000, lmul=100, avl=256: single strip vl=256, last=1.
- Backpressure with sew=010, lmul=001, avl=20 (vlmax=8): hold ready low for 3 cycles on the second strip. vl=8 and idx=1 must stay stable, and the sequence remains 8,8,4.
- sew_enc=101: err pulse, no strip_valid, cfg_ready stays 1. Legal encodings with avl=0: done pulse, no strip_valid.
- abort during the second of three strips (with and without a concurrent handshake): strip_valid low next cycle, no done, IDLE. A following config runs from idx=0.
- rst asserted mid-stream: all outputs at reset values the next cycle. A new config accepted after rst deasserts runs normally.

Source files
------------

// File: rtl/vl_strip_sequencer.sv
// vl_strip_sequencer: strip-mining controller for the vector unit.
// Accepts one configuration (SEW, LMUL, AVL), derives VLMAX = (VLEN/SEW)*LMUL
// and streams per-strip vector lengths over a valid/ready handshake until the
// AVL is exhausted.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_valid/cfg_ready       configuration handshake (ready only when idle)
//   sew_enc, lmul_enc, avl    configuration payload, sampled at acceptance
//   abort                     kill the running operation
//   strip_valid/strip_ready   strip handshake toward the datapath
//   strip_vl/idx/last         strip descriptor
//   busy, done, err           status; done/err are one-cycle pulses
// Every output is a flop; next-output values are derived from next-state values.
module vl_strip_sequencer #(
  parameter int unsigned VLEN = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] sew_enc,
  input  logic [2:0] lmul_enc,
  input  logic [8:0] avl,
  input  logic       abort,
  output logic       strip_valid,
  input  logic       strip_ready,
  output logic [8:0] strip_vl,
  output logic [7:0] strip_idx,
  output logic       strip_last,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned VL_W      = 9;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned ENC_MAX   = 4;
  localparam int unsigned VLMAX_CAP = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [VL_W-1:0]    rem, rem_d;
  logic [VL_W-1:0]    vlmax, vlmax_d;
  logic [IDX_W-1:0]   idx, idx_d;

  logic [VL_W-1:0]    cur_vl;
  logic               cur_last;
  logic               hs;
  logic               enc_bad;
  logic [31:0]        vlmax_raw;
  logic [VL_W-1:0]    vlmax_cfg;

  logic               cfg_ready_d, strip_valid_d, strip_last_d;
  logic               busy_d, done_d, err_d, done_now;
  logic [VL_W-1:0]    strip_vl_d;
  logic [IDX_W-1:0]   strip_idx_d;

  // VLMAX from the offered encodings, saturated to the 9-bit range
  always_comb begin
    vlmax_raw = (32'(VLEN) >> (32'd3 + 32'(sew_enc))) << lmul_enc;
    if (vlmax_raw > 32'(VLMAX_CAP)) begin
      vlmax_cfg = VL_W'(VLMAX_CAP);
    end else begin
      vlmax_cfg = VL_W'(vlmax_raw);
    end
    enc_bad = (32'(sew_enc) > ENC_MAX) || (32'(lmul_enc) > ENC_MAX);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    rem_d    = rem;
    vlmax_d  = vlmax;
    idx_d    = idx;
    err_d    = 1'b0;
    done_now = 1'b0;

    cur_vl   = (rem < vlmax) ? rem : vlmax;
    cur_last = (rem <= vlmax);
    hs       = strip_valid & strip_ready;

    case (state)
      IDLE: begin
        if (cfg_valid) begin
          if (enc_bad) begin
            err_d = 1'b1;
          end else if (avl == '0) begin
            done_now = 1'b1;
          end else begin
            vlmax_d = vlmax_cfg;
            rem_d   = avl;
            idx_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A strip handshaking alongside abort is still consumed
        if (hs) begin
          rem_d = rem - cur_vl;
          idx_d = IDX_W'(idx + IDX_W'(1));
          if (cur_last) begin
            state_d = DONE;
          end
        end
        if (abort) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    strip_valid_d = (state_d == ISSUE);
    strip_vl_d    = '0;
    strip_idx_d   = '0;
    strip_last_d  = 1'b0;
    if (state_d == ISSUE) begin
      strip_vl_d   = (rem_d < vlmax_d) ? rem_d : vlmax_d;
      strip_idx_d  = idx_d;
      strip_last_d = (rem_d <= vlmax_d);
    end
    cfg_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = done_now | (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem         <= '0;
      vlmax       <= '0;
      idx         <= '0;
      cfg_ready   <= 1'b1;
      strip_valid <= 1'b0;
      strip_vl    <= '0;
      strip_idx   <= '0;
      strip_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      rem         <= rem_d;
      vlmax       <= vlmax_d;
      idx         <= idx_d;
      cfg_ready   <= cfg_ready_d;
      strip_valid <= strip_valid_d;
      strip_vl    <= strip_vl_d;
      strip_idx   <= strip_idx_d;
      strip_last  <= strip_last_d;
      busy        <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule
